// File: rtl/input_manager_pkg.sv
// Shared definitions for the input register stage: operand widths, stage-mode
// encodings and the layout of the serial configuration chain.
// Optional feature macro: INPUT_MANAGER_CASCADE_EN (adds ACIN/BCIN/ACOUT/BCOUT
// and the A_INPUT/B_INPUT chain bits).
package input_manager_pkg;

   localparam int A_W = 30;
   localparam int B_W = 18;
   localparam int C_W = 48;

   // Stage-mode codes as loaded from the chain; 2'b11 is reserved and runs as REG_TWO.
   typedef enum logic [1:0] {
      REG_BYPASS = 2'b00,
      REG_ONE    = 2'b01,
      REG_TWO    = 2'b10,
      REG_RSVD   = 2'b11
   } reg_mode_e;

`ifdef INPUT_MANAGER_CASCADE_EN
   localparam int CFG_LEN     = 10;
   localparam int CFG_A_INPUT = 5;
   localparam int CFG_B_INPUT = 6;
`else
   localparam int CFG_LEN     = 8;
`endif

   // Chain positions counted from the configuration_input end.
   localparam int CFG_AREG     = 0;
   localparam int CFG_BREG     = 2;
   localparam int CFG_CREG     = 4;
   localparam int CFG_RSTA_INV = CFG_LEN - 3;
   localparam int CFG_RSTB_INV = CFG_LEN - 2;
   localparam int CFG_RSTC_INV = CFG_LEN - 1;

   // Decoded view of the chain contents.
   typedef struct packed {
      reg_mode_e areg;
      reg_mode_e breg;
      logic      creg;
`ifdef INPUT_MANAGER_CASCADE_EN
      logic      a_input;
      logic      b_input;
`endif
      logic      rsta_inv;
      logic      rstb_inv;
      logic      rstc_inv;
   } cfg_t;

   function automatic cfg_t decode_cfg(input logic [CFG_LEN-1:0] v);
      cfg_t c;
      c.areg     = reg_mode_e'(v[CFG_AREG +: 2]);
      c.breg     = reg_mode_e'(v[CFG_BREG +: 2]);
      c.creg     = v[CFG_CREG];
`ifdef INPUT_MANAGER_CASCADE_EN
      c.a_input  = v[CFG_A_INPUT];
      c.b_input  = v[CFG_B_INPUT];
`endif
      c.rsta_inv = v[CFG_RSTA_INV];
      c.rstb_inv = v[CFG_RSTB_INV];
      c.rstc_inv = v[CFG_RSTC_INV];
      return c;
   endfunction

endpackage

// File: rtl/input_manager_operand_pipe.sv
// Operand pipeline of up to two register stages with per-stage clock enables,
// a shared synchronous reset and a depth mux selecting input or last stage.
// With MAX_DEPTH=1 only the second register carries data; the first stays 0.
module input_manager_operand_pipe
   import input_manager_pkg::*;
#(
   parameter int W         = 30,
   parameter int MAX_DEPTH = 2,
   parameter bit FREEZE    = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   input  reg_mode_e    mode,
   input  logic         ce1,
   input  logic         ce2,
   input  logic         srst,
   output logic [W-1:0] q
);

   reg_mode_e    eff_mode;
   logic [W-1:0] s1;
   logic [W-1:0] s2;

   // Resolve the working depth: reserved code and frozen builds use the deepest stage.
   always_comb begin
      eff_mode = mode;
      if (FREEZE || mode == REG_TWO || mode == REG_RSVD) begin
         eff_mode = (MAX_DEPTH > 1) ? REG_TWO : REG_ONE;
      end
   end

   // First stage: only loads in two-stage mode, forced to zero in one-stage mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
      end else if (srst) begin
         s1 <= '0;
      end else if (eff_mode == REG_ONE) begin
         s1 <= '0;
      end else if (eff_mode == REG_TWO && ce1) begin
         s1 <= d;
      end
   end

   // Second stage: takes the operand directly (one stage) or from the first stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2 <= '0;
      end else if (srst) begin
         s2 <= '0;
      end else if (ce2) begin
         case (eff_mode)
            REG_ONE: s2 <= d;
            REG_TWO: s2 <= s1;
            default: s2 <= s2;
         endcase
      end
   end

   // Bypass passes the operand straight through, even while rst_n is low.
   always_comb begin
      q = (eff_mode == REG_BYPASS) ? d : s2;
   end

endmodule

// File: rtl/input_manager.sv
// Input register stage of the slice: A/B/C operand pipelines whose depth,
// source and reset polarity are loaded through a serial configuration chain.
// Optional feature macro: INPUT_MANAGER_CASCADE_EN (cascade ports and the
// A_INPUT/B_INPUT source-select chain bits; chain is 10 bits, else 8).
module input_manager
   import input_manager_pkg::*;
#(
   parameter bit input_freezed = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [A_W-1:0] A,
   input  logic [B_W-1:0] B,
   input  logic [C_W-1:0] C,
`ifdef INPUT_MANAGER_CASCADE_EN
   input  logic [A_W-1:0] ACIN,
   input  logic [B_W-1:0] BCIN,
`endif
   input  logic           CEA1,
   input  logic           CEA2,
   input  logic           CEB1,
   input  logic           CEB2,
   input  logic           CEC,
   input  logic           RSTA,
   input  logic           RSTB,
   input  logic           RSTC,
   output logic [A_W-1:0] A_out,
   output logic [B_W-1:0] B_out,
   output logic [C_W-1:0] C_out,
`ifdef INPUT_MANAGER_CASCADE_EN
   output logic [A_W-1:0] ACOUT,
   output logic [B_W-1:0] BCOUT,
`endif
   input  logic           configuration_input,
   input  logic           configuration_enable,
   output logic           configuration_output
);

   logic [CFG_LEN-1:0] cfg_q;
   cfg_t               cfg;
   logic [A_W-1:0]     a_src;
   logic [B_W-1:0]     b_src;
   logic               rsta_x;
   logic               rstb_x;
   logic               rstc_x;
   reg_mode_e          c_mode;

   // Configuration chain: shifts one position per enabled clock, never touches data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q <= '0;
      end else if (configuration_enable) begin
         cfg_q <= {cfg_q[CFG_LEN-2:0], configuration_input};
      end
   end

   assign configuration_output = cfg_q[CFG_LEN-1];
   assign cfg                  = decode_cfg(cfg_q);

`ifdef INPUT_MANAGER_CASCADE_EN
   assign a_src = cfg.a_input ? ACIN : A;
   assign b_src = cfg.b_input ? BCIN : B;
`else
   assign a_src = A;
   assign b_src = B;
`endif

   // Stage resets are programmable-polarity versions of the pin resets.
   assign rsta_x = RSTA ^ cfg.rsta_inv;
   assign rstb_x = RSTB ^ cfg.rstb_inv;
   assign rstc_x = RSTC ^ cfg.rstc_inv;
   assign c_mode = cfg.creg ? REG_ONE : REG_BYPASS;

   input_manager_operand_pipe #(
      .W         (A_W),
      .MAX_DEPTH (2),
      .FREEZE    (input_freezed)
   ) u_pipe_a (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (a_src),
      .mode  (cfg.areg),
      .ce1   (CEA1),
      .ce2   (CEA2),
      .srst  (rsta_x),
      .q     (A_out)
   );

   input_manager_operand_pipe #(
      .W         (B_W),
      .MAX_DEPTH (2),
      .FREEZE    (input_freezed)
   ) u_pipe_b (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (b_src),
      .mode  (cfg.breg),
      .ce1   (CEB1),
      .ce2   (CEB2),
      .srst  (rstb_x),
      .q     (B_out)
   );

   // C has a single register; both enables of the pipe follow CEC.
   input_manager_operand_pipe #(
      .W         (C_W),
      .MAX_DEPTH (1),
      .FREEZE    (input_freezed)
   ) u_pipe_c (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (C),
      .mode  (c_mode),
      .ce1   (CEC),
      .ce2   (CEC),
      .srst  (rstc_x),
      .q     (C_out)
   );

`ifdef INPUT_MANAGER_CASCADE_EN
   assign ACOUT = A_out;
   assign BCOUT = B_out;
`endif

endmodule

// File: tb/tb_input_manager.sv
// Self-checking bench for input_manager: behavioural register model compared
// on every falling edge, directed scenarios with literal expectations, a
// queue-based chain scoreboard and a randomized phase.
`timescale 1ns/1ps
module tb_input_manager;
   import input_manager_pkg::*;

   localparam int LEN    = CFG_LEN;
   localparam int P_RSTA = LEN - 3;
   localparam int P_RSTB = LEN - 2;
   localparam int P_RSTC = LEN - 1;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [29:0] a_in = '0;
   logic [17:0] b_in = '0;
   logic [47:0] c_in = '0;
`ifdef INPUT_MANAGER_CASCADE_EN
   logic [29:0] acin = '0;
   logic [17:0] bcin = '0;
   logic [29:0] acout;
   logic [17:0] bcout;
`endif
   logic cea1 = 1'b0, cea2 = 1'b0, ceb1 = 1'b0, ceb2 = 1'b0, cec = 1'b0;
   logic rsta = 1'b0, rstb = 1'b0, rstc = 1'b0;
   logic cfg_in = 1'b0, cfg_en = 1'b0;
   logic [29:0] a_out;
   logic [17:0] b_out;
   logic [47:0] c_out;
   logic        cfg_out;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   input_manager dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .A                    (a_in),
      .B                    (b_in),
      .C                    (c_in),
`ifdef INPUT_MANAGER_CASCADE_EN
      .ACIN                 (acin),
      .BCIN                 (bcin),
`endif
      .CEA1                 (cea1),
      .CEA2                 (cea2),
      .CEB1                 (ceb1),
      .CEB2                 (ceb2),
      .CEC                  (cec),
      .RSTA                 (rsta),
      .RSTB                 (rstb),
      .RSTC                 (rstc),
      .A_out                (a_out),
      .B_out                (b_out),
      .C_out                (c_out),
`ifdef INPUT_MANAGER_CASCADE_EN
      .ACOUT                (acout),
      .BCOUT                (bcout),
`endif
      .configuration_input  (cfg_in),
      .configuration_enable (cfg_en),
      .configuration_output (cfg_out)
   );

   // ---------------- behavioural model ----------------
   logic [LEN-1:0] m_cfg = '0;
   logic [29:0]    m_a1 = '0, m_a2 = '0;
   logic [17:0]    m_b1 = '0, m_b2 = '0;
   logic [47:0]    m_c1 = '0;

   function automatic logic [29:0] m_a_src();
`ifdef INPUT_MANAGER_CASCADE_EN
      return m_cfg[5] ? acin : a_in;
`else
      return a_in;
`endif
   endfunction

   function automatic logic [17:0] m_b_src();
`ifdef INPUT_MANAGER_CASCADE_EN
      return m_cfg[6] ? bcin : b_in;
`else
      return b_in;
`endif
   endfunction

   // Next values of {stage1, stage2} for one operand from the stage rules.
   function automatic logic [95:0] pipe_next(input logic [1:0] mode, input logic rst,
                                             input logic ce1, input logic ce2,
                                             input logic [47:0] src, input logic [47:0] q1,
                                             input logic [47:0] q2);
      logic [47:0] n1;
      logic [47:0] n2;
      n1 = q1;
      n2 = q2;
      if (rst) begin
         n1 = '0;
         n2 = '0;
      end else if (mode == 2'b01) begin
         n1 = '0;
         if (ce2) n2 = src;
      end else if (mode[1]) begin
         if (ce1) n1 = src;
         if (ce2) n2 = q1;
      end
      return {n1, n2};
   endfunction

   function automatic logic [29:0] exp_a();
      return (m_cfg[1:0] == 2'b00) ? m_a_src() : m_a2;
   endfunction
   function automatic logic [17:0] exp_b();
      return (m_cfg[3:2] == 2'b00) ? m_b_src() : m_b2;
   endfunction
   function automatic logic [47:0] exp_c();
      return m_cfg[4] ? m_c1 : c_in;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model_upd
      logic [95:0] r;
      if (!rst_n) begin
         m_cfg <= '0;
         m_a1 <= '0; m_a2 <= '0;
         m_b1 <= '0; m_b2 <= '0;
         m_c1 <= '0;
      end else begin
         r = pipe_next(m_cfg[1:0], rsta ^ m_cfg[P_RSTA], cea1, cea2,
                       48'(m_a_src()), 48'(m_a1), 48'(m_a2));
         m_a1 <= r[77:48];
         m_a2 <= r[29:0];
         r = pipe_next(m_cfg[3:2], rstb ^ m_cfg[P_RSTB], ceb1, ceb2,
                       48'(m_b_src()), 48'(m_b1), 48'(m_b2));
         m_b1 <= r[65:48];
         m_b2 <= r[17:0];
         r = pipe_next({1'b0, m_cfg[4]}, rstc ^ m_cfg[P_RSTC], cec, cec,
                       c_in, 48'd0, m_c1);
         m_c1 <= r[47:0];
         if (cfg_en) m_cfg <= {m_cfg[LEN-2:0], cfg_in};
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_a_out", 48'(a_out), 48'(exp_a()));
         check("m_b_out", 48'(b_out), 48'(exp_b()));
         check("m_c_out", c_out, exp_c());
         check("m_cfg_out", 48'(cfg_out), 48'(m_cfg[LEN-1]));
`ifdef INPUT_MANAGER_CASCADE_EN
         check("m_acout", 48'(acout), 48'(exp_a()));
         check("m_bcout", 48'(bcout), 48'(exp_b()));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_cfg(input logic [LEN-1:0] w);
      for (int i = LEN - 1; i >= 0; i--) begin
         cfg_in = w[i];
         cfg_en = 1'b1;
         step();
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
   endtask

   task automatic set_ce(input logic v);
      cea1 = v; cea2 = v; ceb1 = v; ceb2 = v; cec = v;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rsta = 1'b0; rstb = 1'b0; rstc = 1'b0;
   endtask

   function automatic logic [LEN-1:0] mk_cfg(input logic [1:0] areg, input logic [1:0] breg,
                                              input logic creg, input logic ra,
                                              input logic rb, input logic rc);
      logic [LEN-1:0] w;
      w         = '0;
      w[1:0]    = areg;
      w[3:2]    = breg;
      w[4]      = creg;
      w[P_RSTA] = ra;
      w[P_RSTB] = rb;
      w[P_RSTC] = rc;
      return w;
   endfunction

   logic [0:0]     exp_q[$];
   logic [9:0]     pat;
   logic [29:0]    last_a;
   logic [17:0]    bval;
   logic [LEN-1:0] cur_w;

   // ---------------- stimulus ----------------
   initial begin
      cur_w = '0;
      #2 rst_n = 1'b0;
      step();
      chk_en = 1'b1;
      check("rst_a_out", 48'(a_out), 48'd0);
      check("rst_cfg_out", 48'(cfg_out), 48'd0);
      step();
      rst_n = 1'b1;
      step();

      // Reset clears loaded registers.
      shift_cfg(mk_cfg(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
      set_ce(1'b1);
      for (int i = 0; i < 3; i++) begin
         a_in = 30'($urandom) | 30'd1;
         b_in = 18'($urandom) | 18'd1;
         c_in = {16'($urandom), 32'($urandom)} | 48'd1;
         step();
      end
      a_in = '0; b_in = '0; c_in = '0;
      rst_n = 1'b0;
      #1;
      check("arst_a_out", 48'(a_out), 48'd0);
      check("arst_c_out", c_out, 48'd0);
      check("arst_cfg_out", 48'(cfg_out), 48'd0);
      step();
      rst_n = 1'b1;
      set_ce(1'b0);
      shift_cfg(mk_cfg(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
      check("post_rst_a", 48'(a_out), 48'd0);
      check("post_rst_b", 48'(b_out), 48'd0);
      check("post_rst_c", c_out, 48'd0);

      // Depth: A two stages, B one, C one.
      shift_cfg(mk_cfg(2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
      set_ce(1'b1);
      step();
      a_in = 30'h1234567; b_in = 18'h2ABCD; c_in = 48'hDEADBEEF0001;
      step();
      check("depth_c_1", c_out, 48'hDEADBEEF0001);
      check("depth_b_1", 48'(b_out), 48'h2ABCD);
      check("depth_a_1", 48'(a_out), 48'd0);
      step();
      check("depth_a_2", 48'(a_out), 48'h1234567);

      // CE hold on the second A stage.
      cea2 = 1'b0;
      last_a = '0;
      for (int i = 0; i < 3; i++) begin
         a_in = 30'($urandom);
         last_a = a_in;
         step();
         check("ce_hold_a", 48'(a_out), 48'h1234567);
      end
      cea2 = 1'b1;
      a_in = 30'($urandom);
      step();
      check("ce_release_a", 48'(a_out), 48'(last_a));

      // Inverted B reset polarity: RSTB=0 clears, CE ignored.
      shift_cfg(mk_cfg(2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0));
      rstb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b_in = 18'($urandom) | 18'd1;
         step();
         check("rstb_inv_clear", 48'(b_out), 48'd0);
      end
      rstb = 1'b1;
      bval = 18'h15A5A;
      b_in = bval;
      step();
      check("rstb_inv_pass", 48'(b_out), 48'h15A5A);

      // Chain replay with a mid-shift pause; data keeps flowing.
      pulse_reset();
      exp_q.delete();
      for (int i = 0; i < LEN; i++) exp_q.push_back(1'b0);
      pat = 10'b1011001110;
      for (int i = 0; i < 10 + LEN; i++) begin
         a_in = 30'($urandom);
         c_in = {16'($urandom), 32'($urandom)};
         if (i == 6) begin
            cfg_en = 1'b0;
            for (int k = 0; k < 3; k++) begin
               step();
               check("chain_hold", 48'(cfg_out), 48'(exp_q[0]));
            end
         end
         cfg_in = (i < 10) ? pat[9-i] : 1'b0;
         cfg_en = 1'b1;
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(cfg_in);
         check("chain_out", 48'(cfg_out), 48'(exp_q[0]));
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;

`ifdef INPUT_MANAGER_CASCADE_EN
      // Cascade source on A with one stage.
      pulse_reset();
      begin
         logic [LEN-1:0] w;
         w = mk_cfg(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         w[5] = 1'b1;
         shift_cfg(w);
      end
      acin = 30'h3FFFFFFF;
      a_in = '0;
      set_ce(1'b1);
      step();
      check("casc_a_out", 48'(a_out), 48'h3FFFFFFF);
      check("casc_acout", 48'(acout), 48'h3FFFFFFF);
`endif

      // Randomized phase checked by the per-cycle model compare.
      pulse_reset();
      cur_w = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc % 50 == 0) begin
            cur_w = LEN'($urandom);
            shift_cfg(cur_w);
         end
         if (cyc == 230) begin
            pulse_reset();
            cur_w = '0;
         end
         a_in = 30'($urandom);
         b_in = 18'($urandom);
         c_in = {16'($urandom), 32'($urandom)};
`ifdef INPUT_MANAGER_CASCADE_EN
         acin = 30'($urandom);
         bcin = 18'($urandom);
`endif
         cea1 = ($urandom_range(0, 3) != 0);
         cea2 = ($urandom_range(0, 3) != 0);
         ceb1 = ($urandom_range(0, 3) != 0);
         ceb2 = ($urandom_range(0, 3) != 0);
         cec  = ($urandom_range(0, 3) != 0);
         rsta = cur_w[P_RSTA] ^ ($urandom_range(0, 7) == 0);
         rstb = cur_w[P_RSTB] ^ ($urandom_range(0, 7) == 0);
         rstc = cur_w[P_RSTC] ^ ($urandom_range(0, 7) == 0);
         step();
      end

      chk_en = 1'b0;
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Bound on the whole run.
   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog: run did not end, got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
